id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Instruction-decode stage directly downstream of the instruction fetch unit.
- Captures the 32-bit MIPS instruction word from fetch and splits it into fields.
- Generates immediate extension, destination register and register-write control.
- Holds the 32x32 general register file: two read ports, one write-back port with same-cycle bypass.
- All outputs are registered: one ID pipeline register feeding the execute stage.

Parameters:
- RF_DEPTH, 32, number of general registers (address width fixed at 5).
- RESET_PC_INST, 32'h00000000, instruction value held in the ID register after reset (decodes as SLL $0,$0,0, a NOP).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low: rst==0 at a rising clk edge resets the block.
- inst_code  input  32  instruction word from the fetch stage.
- inst_valid  input  1  inst_code holds a real instruction this cycle.
- stall  input  1  hold the ID register contents.
- flush  input  1  squash the instruction being captured.
- wb_en  input  1  register write-back enable.
- wb_addr  input  5  write-back register index.
- wb_data  input  32  write-back data.
- op  output  6  inst[31:26].
- funct  output  6  inst[5:0].
- rs, rt, rd  output  5 each  inst[25:21], inst[20:16], inst[15:11].
- shamt  output  5  inst[10:6].
- imm_ext  output  32  extended immediate.
- jaddr  output  26  inst[25:0].
- rs_data, rt_data  output  32 each  register operands.
- dst_addr  output  5  destination register.
- reg_write  output  1  instruction writes dst_addr.
- id_valid  output  1  ID register holds a valid instruction.
- illegal  output  1  unsupported opcode/funct.

Behaviour:
- Reset: all 32 registers cleared to 0; ID register loaded with RESET_PC_INST; every output 0.
- Latency: instruction and operands sampled at edge N appear on the outputs after edge N, i.e. one cycle.
- Update priority at each edge when rst==1:
  1. flush: id_valid=0, reg_write=0, illegal=0, fields decode a NOP.
  2. else stall: all outputs hold.
  3. else capture: capture inst_code; id_valid=inst_valid; when inst_valid==0, reg_write=0 and illegal=0.
- Register file write: when wb_en && wb_addr!=0, reg[wb_addr]<=wb_data. Occurs regardless of stall/flush; writes to $0 are ignored.
- Register file reads: reg[0] always reads 0.
- Bypass: when capturing and wb_en && wb_addr==rs && rs!=0, rs_data<=wb_data. Same rule for rt.
- While stalled, rs_data/rt_data hold and are not refreshed by write-back.
- Supported R-type (op=0), by funct: ADD 20, ADDU 21, SUB 22, SUBU 23, AND 24, OR 25, XOR 26, NOR 27, SLT 2A, SLL 00, SRL 02, SRA 03, JR 08.
- Supported I/J ops: BEQ 04, BNE 05, ADDI 08, ADDIU 09, SLTI 0A, ANDI 0C, ORI 0D, XORI 0E, LUI 0F, LW 23, SW 2B, J 02, JAL 03.
- imm_ext: ANDI/ORI/XORI zero-extend inst[15:0]; LUI gives {inst[15:0],16'h0}; all other ops sign-extend.
- dst_addr:
  - R-type: rd.
  - ADDI, ADDIU, SLTI, ANDI, ORI, XORI, LUI, LW: rt.
  - JAL: 31.
  - Otherwise: 0.
- reg_write=1 for R-type except JR, ALU-immediate ops, LUI, LW, JAL; forced 0 when dst_addr==0.
- Unsupported op/funct: illegal=1, reg_write=0, id_valid follows inst_valid.
- Reset asserted mid-stall or mid-flush: reset wins.

Test Plan:
- Reset: rst=0 for 2 cycles, then release -> all outputs 0; reading rs=5 gives rs_data=0.
- Write then read: wb_en=1, wb_addr=8, wb_data=32'h1234_5678. Next cycle capture ADD $10,$8,$9 (32'h01095020) -> after one edge rs_data=32'h12345678, rt_data=0, dst_addr=10, reg_write=1, illegal=0.
- Bypass: capture 32'h01095020 in the same cycle as wb_en=1, wb_addr=9, wb_data=32'hDEAD_BEEF -> rt_data=32'hDEADBEEF.
- $0 write: wb_en=1, wb_addr=0, wb_data=32'hFFFFFFFF, then read rs=0 -> rs_data=0.
- Immediate extension:
  - ORI $8,$0,0x8001 -> imm_ext=32'h00008001, dst_addr=8.
  - ADDI $8,$0,-1 -> imm_ext=32'hFFFFFFFF.
  - LUI $8,0xABCD -> imm_ext=32'hABCD0000.
  - JAL -> dst_addr=31.
- Stall/flush/illegal:
  - stall=1 while inst_code changes -> outputs unchanged for all stalled cycles.
  - stall=1 and flush=1 together -> id_valid=0, reg_write=0.
  - op=6'h3F -> illegal=1, reg_write=0.

Source files
------------

// File: rtl/id_stage_if.sv
// Bundle between fetch/write-back and the decode stage, plus the decoded
// outputs that feed execute.
interface id_stage_if;
  logic [31:0] inst_code;
  logic        inst_valid;
  logic        stall;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [31:0] imm_ext;
  logic [25:0] jaddr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [4:0]  dst_addr;
  logic        reg_write;
  logic        id_valid;
  logic        illegal;

  modport master (
    output inst_code, inst_valid, stall, flush, wb_en, wb_addr, wb_data,
    input  op, funct, rs, rt, rd, shamt, imm_ext, jaddr, rs_data, rt_data,
           dst_addr, reg_write, id_valid, illegal
  );

  modport slave (
    input  inst_code, inst_valid, stall, flush, wb_en, wb_addr, wb_data,
    output op, funct, rs, rt, rd, shamt, imm_ext, jaddr, rs_data, rt_data,
           dst_addr, reg_write, id_valid, illegal
  );
endinterface

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: field split, immediate/destination decode,
// 32x32 register file with write-back bypass, one registered ID stage.
module id_stage #(
  parameter int          RF_DEPTH      = 32,
  parameter logic [31:0] RESET_PC_INST = 32'h0000_0000
) (
  input  logic     clk,
  input  logic     rst,
  id_stage_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // Logical immediates zero-extend, LUI shifts up, everything else sign-extends.
  function automatic logic [31:0] imm_extend(input logic [5:0] op,
                                             input logic [15:0] imm);
    logic signed [15:0] simm;
    simm = $signed(imm);
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: imm_extend = {16'h0000, imm};
      OP_LUI:                   imm_extend = {imm, 16'h0000};
      default:                  imm_extend = 32'(simm);
    endcase
  endfunction

  logic [31:0] r_rf [RF_DEPTH];

  logic [31:0] r_inst_p1;
  logic        r_vld_p1;
  logic        r_reg_write_p1;
  logic        r_illegal_p1;
  logic [31:0] r_imm_ext_p1;
  logic [31:0] r_rs_data_p1;
  logic [31:0] r_rt_data_p1;
  logic [4:0]  r_dst_addr_p1;

  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_dst;
  logic        w_wr_en;
  logic        w_illegal;
  logic [31:0] w_rs_data;
  logic [31:0] w_rt_data;
  logic        w_wb_live;

  assign w_op    = bus.inst_code[31:26];
  assign w_funct = bus.inst_code[5:0];
  assign w_rs    = bus.inst_code[25:21];
  assign w_rt    = bus.inst_code[20:16];
  assign w_rd    = bus.inst_code[15:11];

  assign w_wb_live = bus.wb_en && (bus.wb_addr != 5'd0);

  // Register file: writes land regardless of stall/flush; $0 is never written.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < RF_DEPTH; i++) r_rf[i] <= '0;
    end else if (w_wb_live) begin
      r_rf[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_comb begin
    if (w_rs == 5'd0)                             w_rs_data = '0;
    else if (w_wb_live && bus.wb_addr == w_rs)    w_rs_data = bus.wb_data;
    else                                          w_rs_data = r_rf[w_rs];
    if (w_rt == 5'd0)                             w_rt_data = '0;
    else if (w_wb_live && bus.wb_addr == w_rt)    w_rt_data = bus.wb_data;
    else                                          w_rt_data = r_rf[w_rt];
  end

  always_comb begin
    w_dst     = 5'd0;
    w_wr_en   = 1'b0;
    w_illegal = 1'b0;
    if (w_op == OP_RTYPE) begin
      w_dst = w_rd;
      case (w_funct)
        FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
        FN_SLT, FN_SLL, FN_SRL, FN_SRA: w_wr_en = 1'b1;
        FN_JR:                          w_wr_en = 1'b0;
        default:                        w_illegal = 1'b1;
      endcase
    end else begin
      case (w_op)
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
          w_dst   = w_rt;
          w_wr_en = 1'b1;
        end
        OP_JAL: begin
          w_dst   = 5'd31;
          w_wr_en = 1'b1;
        end
        OP_BEQ, OP_BNE, OP_SW, OP_J: w_wr_en = 1'b0;
        default:                     w_illegal = 1'b1;
      endcase
    end
    if (w_illegal || w_dst == 5'd0) w_wr_en = 1'b0;
  end

  // ---- ID pipeline register (fetch -> execute boundary) ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_inst_p1      <= RESET_PC_INST;
      r_vld_p1       <= 1'b0;
      r_reg_write_p1 <= 1'b0;
      r_illegal_p1   <= 1'b0;
      r_imm_ext_p1   <= '0;
      r_rs_data_p1   <= '0;
      r_rt_data_p1   <= '0;
      r_dst_addr_p1  <= '0;
    end else if (bus.flush) begin
      r_inst_p1      <= '0;
      r_vld_p1       <= 1'b0;
      r_reg_write_p1 <= 1'b0;
      r_illegal_p1   <= 1'b0;
      r_imm_ext_p1   <= '0;
      r_rs_data_p1   <= '0;
      r_rt_data_p1   <= '0;
      r_dst_addr_p1  <= '0;
    end else if (!bus.stall) begin
      r_inst_p1      <= bus.inst_code;
      r_vld_p1       <= bus.inst_valid;
      r_reg_write_p1 <= bus.inst_valid && w_wr_en;
      r_illegal_p1   <= bus.inst_valid && w_illegal;
      r_imm_ext_p1   <= imm_extend(w_op, bus.inst_code[15:0]);
      r_rs_data_p1   <= w_rs_data;
      r_rt_data_p1   <= w_rt_data;
      r_dst_addr_p1  <= w_dst;
    end
  end

  assign bus.op        = r_inst_p1[31:26];
  assign bus.rs        = r_inst_p1[25:21];
  assign bus.rt        = r_inst_p1[20:16];
  assign bus.rd        = r_inst_p1[15:11];
  assign bus.shamt     = r_inst_p1[10:6];
  assign bus.funct     = r_inst_p1[5:0];
  assign bus.jaddr     = r_inst_p1[25:0];
  assign bus.imm_ext   = r_imm_ext_p1;
  assign bus.rs_data   = r_rs_data_p1;
  assign bus.rt_data   = r_rt_data_p1;
  assign bus.dst_addr  = r_dst_addr_p1;
  assign bus.reg_write = r_reg_write_p1;
  assign bus.id_valid  = r_vld_p1;
  assign bus.illegal   = r_illegal_p1;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: stimulus pushes expected ID-register contents,
// a monitor pops and compares one entry after every rising edge.
module tb_id_stage;
  typedef logic [161:0] exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  id_stage_if bus ();

  id_stage dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  exp_t  q  [$];
  string nq [$];
  int    nvec = 0;
  int    nerr = 0;

  function automatic exp_t mk(input logic [31:0] inst, input logic vld,
                              input logic rw, input logic ill,
                              input logic [31:0] imm, input logic [31:0] rsd,
                              input logic [31:0] rtd, input logic [4:0] dst);
    logic [25:0] ja;
    ja = inst[25:0];
    return {inst, ja, vld, rw, ill, imm, rsd, rtd, dst};
  endfunction

  task automatic step(input string nm, input logic r, input logic st,
                      input logic fl, input logic iv, input logic [31:0] ic,
                      input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input exp_t e);
    @(negedge clk);
    rst_n          = r;
    bus.stall      = st;
    bus.flush      = fl;
    bus.inst_valid = iv;
    bus.inst_code  = ic;
    bus.wb_en      = we;
    bus.wb_addr    = wa;
    bus.wb_data    = wd;
    q.push_back(e);
    nq.push_back(nm);
  endtask

  initial begin : monitor
    exp_t  e;
    exp_t  act;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e  = q.pop_front();
        nm = nq.pop_front();
        act = {bus.op, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct, bus.jaddr,
               bus.id_valid, bus.reg_write, bus.illegal, bus.imm_ext,
               bus.rs_data, bus.rt_data, bus.dst_addr};
        nvec++;
        if (act !== e) begin
          nerr++;
          $display("FAIL %s: got %h required %h", nm, act, e);
        end
      end
    end
  end

  initial begin : stim
    exp_t z;
    exp_t sw_e;
    z = mk(32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
    bus.stall = 0; bus.flush = 0; bus.inst_valid = 0; bus.inst_code = '0;
    bus.wb_en = 0; bus.wb_addr = '0; bus.wb_data = '0;

    step("reset0", 0, 0, 0, 1, 32'h01095020, 0, 0, 0, z);
    step("reset1", 0, 0, 0, 1, 32'h01095020, 0, 0, 0, z);
    step("rs5_zero", 1, 0, 0, 1, 32'h00A00000, 1, 5'd8, 32'h1234_5678,
         mk(32'h00A00000, 1, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0));
    step("add_read", 1, 0, 0, 1, 32'h01095020, 0, 0, 0,
         mk(32'h01095020, 1, 1, 0, 32'h00005020, 32'h12345678, 32'h0, 5'd10));
    step("bypass_rt", 1, 0, 0, 1, 32'h01095020, 1, 5'd9, 32'hDEAD_BEEF,
         mk(32'h01095020, 1, 1, 0, 32'h00005020, 32'h12345678, 32'hDEADBEEF, 5'd10));
    step("wr_zero", 1, 0, 0, 1, 32'h00000000, 1, 5'd0, 32'hFFFF_FFFF,
         mk(32'h0, 1, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0));
    step("rd_zero", 1, 0, 0, 1, 32'h00004020, 0, 0, 0,
         mk(32'h00004020, 1, 1, 0, 32'h00004020, 32'h0, 32'h0, 5'd8));
    step("ori_zext", 1, 0, 0, 1, 32'h34088001, 0, 0, 0,
         mk(32'h34088001, 1, 1, 0, 32'h00008001, 32'h0, 32'h12345678, 5'd8));
    step("addi_sext", 1, 0, 0, 1, 32'h2008FFFF, 0, 0, 0,
         mk(32'h2008FFFF, 1, 1, 0, 32'hFFFFFFFF, 32'h0, 32'h12345678, 5'd8));
    step("lui", 1, 0, 0, 1, 32'h3C08ABCD, 0, 0, 0,
         mk(32'h3C08ABCD, 1, 1, 0, 32'hABCD0000, 32'h0, 32'h12345678, 5'd8));
    step("jal", 1, 0, 0, 1, 32'h0C000100, 0, 0, 0,
         mk(32'h0C000100, 1, 1, 0, 32'h00000100, 32'h0, 32'h0, 5'd31));
    sw_e = mk(32'hAD090004, 1, 0, 0, 32'h00000004, 32'h12345678, 32'hDEADBEEF, 5'd0);
    step("sw", 1, 0, 0, 1, 32'hAD090004, 0, 0, 0, sw_e);
    step("stall0", 1, 1, 0, 1, 32'h01095020, 1, 5'd8, 32'h1111_1111, sw_e);
    step("stall1", 1, 1, 0, 0, 32'h34088001, 1, 5'd8, 32'h1111_1111, sw_e);
    step("stall2", 1, 1, 0, 1, 32'hFC000000, 0, 0, 0, sw_e);
    step("post_stall", 1, 0, 0, 1, 32'hAD090004, 0, 0, 0,
         mk(32'hAD090004, 1, 0, 0, 32'h00000004, 32'h11111111, 32'hDEADBEEF, 5'd0));
    step("stall_flush", 1, 1, 1, 1, 32'h01095020, 0, 0, 0, z);
    step("illegal_op", 1, 0, 0, 1, 32'hFC0A0005, 0, 0, 0,
         mk(32'hFC0A0005, 1, 0, 1, 32'h00000005, 32'h0, 32'h0, 5'd0));
    step("illegal_fn", 1, 0, 0, 1, 32'h01090001, 0, 0, 0,
         mk(32'h01090001, 1, 0, 1, 32'h00000001, 32'h11111111, 32'hDEADBEEF, 5'd0));
    step("not_valid", 1, 0, 0, 0, 32'h01095020, 0, 0, 0,
         mk(32'h01095020, 0, 0, 0, 32'h00005020, 32'h11111111, 32'hDEADBEEF, 5'd10));
    step("jr", 1, 0, 0, 1, 32'h03E00008, 0, 0, 0,
         mk(32'h03E00008, 1, 0, 0, 32'h00000008, 32'h0, 32'h0, 5'd0));
    step("flush", 1, 0, 1, 1, 32'h01095020, 0, 0, 0, z);
    step("rst_in_stall", 0, 1, 1, 1, 32'h01095020, 0, 0, 0, z);
    step("rf_cleared", 1, 0, 0, 1, 32'hAD090004, 0, 0, 0,
         mk(32'hAD090004, 1, 0, 0, 32'h00000004, 32'h0, 32'h0, 5'd0));
    step("beq_neg", 1, 0, 0, 1, 32'h1109FFFE, 0, 0, 0,
         mk(32'h1109FFFE, 1, 0, 0, 32'hFFFFFFFE, 32'h0, 32'h0, 5'd0));

    @(negedge clk);
    bus.wb_en = 0; bus.stall = 0; bus.flush = 0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      nerr++;
      $display("FAIL drain: got %0d pending required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
